// File: rtl/seg7_pkg.sv
// seg7_pkg: shared digit count, scan phase type, display record and anode pattern helper
package seg7_pkg;
  localparam int NDIG = 4;
  typedef enum logic {ST_BLANK, ST_SHOW} st_e;
  typedef struct packed {
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   dp;
    logic [NDIG-1:0]   en;
  } disp_t;
  function automatic logic [NDIG-1:0] line_drive(input logic [1:0] idx, input logic en, input logic act_low);
    logic [NDIG-1:0] oh;
    oh = en ? NDIG'(1) << idx : '0;
    return oh ^ {NDIG{act_low}};
  endfunction
endpackage

// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: load-side inputs and display-side outputs of the digit scanner
interface seg7_scan_mux_if;
  import seg7_pkg::*;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   dp_in;
  logic [NDIG-1:0]   digit_en;
  logic              load;
  logic              busy;
  logic [3:0]        nibble;
  logic [NDIG-1:0]   line;
  logic              dp;
  logic              frame_done;
  modport master(output value, dp_in, digit_en, load, input busy, nibble, line, dp, frame_done);
  modport slave(input value, dp_in, digit_en, load, output busy, nibble, line, dp, frame_done);
endinterface

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: slot counter, digit index, blank/show phase and frame pulse, exposing next-state for aligned outputs
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] idx_n,
  output logic       show_n,
  output logic       frame_done
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  st_e           st_q, st_d;
  logic          frame_done_q, frame_done_d;
  always_comb begin
    cnt_d        = cnt_q == LAST ? '0 : cnt_q + 1'b1;
    idx_d        = cnt_q == LAST ? idx_q + 2'd1 : idx_q;
    st_d         = st_q == ST_BLANK
                 ? ((BLANK_CYCLES == 0 || cnt_q == BLAST) ? ST_SHOW : ST_BLANK)
                 : ((cnt_q == LAST && BLANK_CYCLES != 0) ? ST_BLANK : ST_SHOW);
    frame_done_d = cnt_d == LAST && idx_d == 2'd3;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      st_q         <= ST_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      st_q         <= st_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign idx_n      = idx_d;
  assign show_n     = st_d == ST_SHOW;
  assign frame_done = frame_done_q;
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: 4-digit scanner with frame-aligned commit of loaded values and registered, skew-free outputs
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit LINE_ACT_LOW = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  seg7_scan_mux_if.slave  bus
);
  disp_t           pend_q, pend_d, act_q, act_d;
  logic            busy_q, busy_d;
  logic [3:0]      nibble_q, nibble_d;
  logic [NDIG-1:0] line_q, line_d;
  logic            dp_q, dp_d;
  logic [1:0]      idx_n;
  logic            show_n, frame_done, commit;
  seg7_slot_timer #(.SLOT_CYCLES(SLOT_CYCLES), .BLANK_CYCLES(BLANK_CYCLES)) u_timer (
    .clk(clk), .rst_n(rst_n), .idx_n(idx_n), .show_n(show_n), .frame_done(frame_done)
  );
  always_comb begin
    commit   = frame_done & busy_q;
    act_d    = commit ? pend_q : act_q;
    pend_d   = bus.load ? {bus.value, bus.dp_in, bus.digit_en} : pend_q;
    busy_d   = bus.load | (busy_q & ~commit);
    nibble_d = act_d.value[4*idx_n +: 4];
    dp_d     = act_d.dp[idx_n] & act_d.en[idx_n];
    line_d   = line_drive(idx_n, show_n & act_d.en[idx_n], LINE_ACT_LOW);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q   <= '0;
      act_q    <= '0;
      busy_q   <= 1'b0;
      nibble_q <= '0;
      dp_q     <= 1'b0;
      line_q   <= line_drive(2'd0, 1'b0, LINE_ACT_LOW);
    end else begin
      pend_q   <= pend_d;
      act_q    <= act_d;
      busy_q   <= busy_d;
      nibble_q <= nibble_d;
      dp_q     <= dp_d;
      line_q   <= line_d;
    end
  end
  assign bus.busy       = busy_q;
  assign bus.nibble     = nibble_q;
  assign bus.dp         = dp_q;
  assign bus.line       = line_q;
  assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: random and directed loads against a cycle-count reference model, scoreboard-checked on both anode polarities
module tb_seg7_scan_mux;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;
  typedef struct packed {
    int         cyc;
    logic [3:0] nibble;
    logic [3:0] line;
    logic       dp;
    logic       busy;
    logic       fd;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  seg7_scan_mux_if bus0();
  seg7_scan_mux_if bus1();
  assign bus1.value    = bus0.value;
  assign bus1.dp_in    = bus0.dp_in;
  assign bus1.digit_en = bus0.digit_en;
  assign bus1.load     = bus0.load;
  seg7_scan_mux #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .LINE_ACT_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  seg7_scan_mux #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .LINE_ACT_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  exp_t        q[$];
  int          k;
  logic [15:0] m_pv, m_av;
  logic [3:0]  m_pdp, m_pen, m_adp, m_aen;
  logic        m_busy;
  int          checks = 0;
  int          errors = 0;
  task automatic chk(input string name, input int t, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, t, act, req);
    end
  endtask
  task automatic step();
    exp_t e;
    int cnt, idx;
    logic fd;
    @(posedge clk);
    if (!rst_n) begin
      k = 0; m_busy = 0;
      m_pv = '0; m_pdp = '0; m_pen = '0;
      m_av = '0; m_adp = '0; m_aen = '0;
    end else begin
      fd = (k % SLOT == SLOT - 1) && ((k / SLOT) % 4 == 3);
      if (fd && m_busy) begin
        m_av = m_pv; m_adp = m_pdp; m_aen = m_pen;
      end
      if (bus0.load) begin
        m_pv = bus0.value; m_pdp = bus0.dp_in; m_pen = bus0.digit_en; m_busy = 1;
      end else if (fd) m_busy = 0;
      k++;
    end
    #1;
    cnt      = k % SLOT;
    idx      = (k / SLOT) % 4;
    e.cyc    = k;
    e.line   = (cnt >= BLANK && m_aen[idx]) ? 4'b0001 << idx : 4'b0000;
    e.nibble = m_av[4*idx +: 4];
    e.dp     = m_adp[idx] & m_aen[idx];
    e.busy   = m_busy;
    e.fd     = cnt == SLOT - 1 && idx == 3;
    q.push_back(e);
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic ld(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
    bus0.value = v; bus0.dp_in = d; bus0.digit_en = en; bus0.load = 1'b1;
    step();
    bus0.load = 1'b0;
  endtask
  task automatic wait_k(input int m, input int r);
    for (int i = 0; i < 200 && k % m != r; i++) step();
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("nibble",       e.cyc, bus0.nibble,            e.nibble);
      chk("line",         e.cyc, bus0.line,              e.line);
      chk("dp",           e.cyc, {3'b0, bus0.dp},        {3'b0, e.dp});
      chk("busy",         e.cyc, {3'b0, bus0.busy},      {3'b0, e.busy});
      chk("frame_done",   e.cyc, {3'b0, bus0.frame_done},{3'b0, e.fd});
      chk("line_actlow",  e.cyc, bus1.line,              ~e.line);
      chk("nibble_actlow",e.cyc, bus1.nibble,            e.nibble);
    end
  end
  initial begin
    bus0.value = '0; bus0.dp_in = '0; bus0.digit_en = '0; bus0.load = 1'b0;
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(40);
    ld(16'h3A7C, 4'b0100, 4'b1111);
    run(100);
    ld(16'h1234, 4'b0000, 4'b1111);
    wait_k(FRAME, 0);
    wait_k(FRAME, 10);
    ld(16'h5678, 4'b0000, 4'b1111);
    run(70);
    ld(16'hAAAA, 4'b0001, 4'b1111);
    wait_k(FRAME, FRAME - 1);
    ld(16'hBBBB, 4'b0010, 4'b1111);
    run(70);
    wait_k(FRAME, 3);
    ld(16'h1111, 4'b1111, 4'b1111);
    run(5);
    ld(16'h2222, 4'b0000, 4'b1111);
    run(70);
    ld(16'($urandom), 4'b1111, 4'b0101);
    run(70);
    ld(16'h9999, 4'b1000, 4'b1111);
    wait_k(SLOT, 4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(70);
    repeat (400) begin
      if ($urandom_range(0, 5) == 0) ld(16'($urandom), 4'($urandom), 4'($urandom));
      else step();
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
